tile_video_mem: RTL and testbench



---
 rtl/tile_video_mem.sv | 226 ++++++++++++++++++++++
 tb/tb_tile_video_mem.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_video_mem.sv
// Tile-based video memory: a framebuffer of tile indices, a tile pixel store and a control
// register bank on one CPU port, plus a 3-stage pixel fetch pipeline for the VGA timing block.
module tile_video_mem #(
   parameter int          TILE_LOG2     = 3,
   parameter int          MAP_COLS_LOG2 = 7,
   parameter int          MAP_ROWS_LOG2 = 6,
   parameter int          TILE_IDX_W    = 7,
   parameter int          PIXEL_W       = 12,
   parameter int          SCALE_MAX     = 3,
   parameter logic [15:0] TILEMAP_BASE  = 16'hC000,
   parameter logic [15:0] FB_BASE       = 16'hE000,
   parameter logic [15:0] REG_BASE      = 16'hFFF8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ren,
   input  logic [15:0]        raddr,
   output logic [15:0]        rdata,
   output logic               rvalid,
   input  logic               wen,
   input  logic [15:0]        waddr,
   input  logic [15:0]        wdata,
   input  logic               frame_start,
   input  logic               pix_req,
   input  logic [9:0]         pixel_x,
   input  logic [9:0]         pixel_y,
   output logic [PIXEL_W-1:0] pixel,
   output logic               pixel_valid
);

   localparam int MX_W     = MAP_COLS_LOG2 + TILE_LOG2;
   localparam int MY_W     = MAP_ROWS_LOG2 + TILE_LOG2;
   localparam int TS_AW    = TILE_IDX_W + 2 * TILE_LOG2;
   localparam int FB_AW    = MAP_COLS_LOG2 + MAP_ROWS_LOG2 - 1;
   localparam int TS_DEPTH = 1 << TS_AW;
   localparam int FB_DEPTH = 1 << FB_AW;
   localparam int WR       = 0;
   localparam int RD       = 1;

   typedef enum logic [1:0] {SRC_NONE, SRC_TS, SRC_FB, SRC_REG} src_t;

   function automatic logic in_range(input logic [15:0] a, input logic [15:0] base,
                                     input int depth);
      logic [16:0] lo;
      lo = {1'b0, base};
      return ({1'b0, a} >= lo) && ({1'b0, a} < lo + 17'(depth));
   endfunction

   logic [15:0]      tile_mem [TS_DEPTH];
   logic [15:0]      fb_mem   [FB_DEPTH];

   logic [15:0]      port_addr [2];
   logic             ts_hit    [2];
   logic             fb_hit    [2];
   logic             reg_hit   [2];
   logic [TS_AW-1:0] ts_off    [2];
   logic [FB_AW-1:0] fb_off    [2];
   logic [2:0]       reg_off   [2];

   assign port_addr[WR] = waddr;
   assign port_addr[RD] = raddr;

   // Identical region decode for the write port (0) and the read port (1).
   for (genvar gi = 0; gi < 2; gi++) begin : g_decode
      assign ts_hit[gi]  = in_range(port_addr[gi], TILEMAP_BASE, TS_DEPTH);
      assign fb_hit[gi]  = in_range(port_addr[gi], FB_BASE, FB_DEPTH);
      assign reg_hit[gi] = in_range(port_addr[gi], REG_BASE, 8);
      assign ts_off[gi]  = TS_AW'(port_addr[gi] - TILEMAP_BASE);
      assign fb_off[gi]  = FB_AW'(port_addr[gi] - FB_BASE);
      assign reg_off[gi] = 3'(port_addr[gi] - REG_BASE);
   end

   logic [1:0]         scale_reg;
   logic [15:0]        hscroll_reg;
   logic [15:0]        vscroll_reg;
   logic               en_reg;
   logic [PIXEL_W-1:0] bg_reg;
   logic [1:0]         sh_scale_reg;
   logic [15:0]        sh_hscroll_reg;
   logic [15:0]        sh_vscroll_reg;

   // Shadows sample the pre-write live values, so a same-cycle write waits a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scale_reg      <= '0;
         hscroll_reg    <= '0;
         vscroll_reg    <= '0;
         en_reg         <= 1'b0;
         bg_reg         <= '0;
         sh_scale_reg   <= '0;
         sh_hscroll_reg <= '0;
         sh_vscroll_reg <= '0;
      end else begin
         if (wen && reg_hit[WR]) begin
            case (reg_off[WR])
               3'd0:    scale_reg   <= wdata[1:0];
               3'd1:    hscroll_reg <= wdata;
               3'd2:    vscroll_reg <= wdata;
               3'd3:    en_reg      <= wdata[0];
               3'd4:    bg_reg      <= wdata[PIXEL_W-1:0];
               default: ;
            endcase
         end
         if (frame_start) begin
            sh_scale_reg   <= scale_reg;
            sh_hscroll_reg <= hscroll_reg;
            sh_vscroll_reg <= vscroll_reg;
         end
      end
   end

   logic [1:0]          es;
   logic [MX_W-1:0]     mx;
   logic [MY_W-1:0]     my;
   logic [FB_AW-1:0]    fb_pix_addr;
   logic [TS_AW-1:0]    ts_pix_addr;
   logic [TILE_IDX_W-1:0] fb_lo_idx_reg;
   logic [TILE_IDX_W-1:0] fb_hi_idx_reg;
   logic                odd_reg;
   logic [TILE_LOG2-1:0] mx_lo_reg;
   logic [TILE_LOG2-1:0] my_lo_reg;
   logic [PIXEL_W-1:0]  tile_pix_reg;
   logic                s1_valid_reg;
   logic                s2_valid_reg;
   logic [15:0]         ts_cpu_reg;
   logic [15:0]         fb_cpu_reg;

   always_comb begin
      es = (int'(sh_scale_reg) > SCALE_MAX) ? 2'(SCALE_MAX) : sh_scale_reg;
      mx = MX_W'(16'(pixel_x >> es) + sh_hscroll_reg);
      my = MY_W'(16'(pixel_y >> es) + sh_vscroll_reg);
   end

   assign fb_pix_addr = {my[MY_W-1:TILE_LOG2], mx[MX_W-1:TILE_LOG2+1]};
   assign ts_pix_addr = {odd_reg ? fb_hi_idx_reg : fb_lo_idx_reg, my_lo_reg, mx_lo_reg};

   always_ff @(posedge clk) begin
      if (wen && fb_hit[WR])
         fb_mem[fb_off[WR]] <= wdata;
      if (ren)
         fb_cpu_reg <= fb_mem[fb_off[RD]];
      fb_lo_idx_reg <= fb_mem[fb_pix_addr][TILE_IDX_W-1:0];
      fb_hi_idx_reg <= fb_mem[fb_pix_addr][8 +: TILE_IDX_W];
   end

   always_ff @(posedge clk) begin
      if (wen && ts_hit[WR])
         tile_mem[ts_off[WR]] <= wdata;
      if (ren)
         ts_cpu_reg <= tile_mem[ts_off[RD]];
      tile_pix_reg <= tile_mem[ts_pix_addr][PIXEL_W-1:0];
   end

   always_ff @(posedge clk) begin
      odd_reg   <= mx[TILE_LOG2];
      mx_lo_reg <= mx[TILE_LOG2-1:0];
      my_lo_reg <= my[TILE_LOG2-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         pixel_valid  <= 1'b0;
         pixel        <= '0;
      end else begin
         s1_valid_reg <= pix_req;
         s2_valid_reg <= s1_valid_reg;
         pixel_valid  <= s2_valid_reg;
         pixel        <= en_reg ? tile_pix_reg : bg_reg;
      end
   end

   src_t        rd_src;
   src_t        rd_src_reg;
   logic [15:0] reg_rd_val;
   logic [15:0] reg_rd_reg;

   always_comb begin
      rd_src = SRC_NONE;
      if (ts_hit[RD])
         rd_src = SRC_TS;
      else if (fb_hit[RD])
         rd_src = SRC_FB;
      else if (reg_hit[RD])
         rd_src = SRC_REG;
   end

   always_comb begin
      reg_rd_val = '0;
      case (reg_off[RD])
         3'd0:    reg_rd_val = 16'(scale_reg);
         3'd1:    reg_rd_val = hscroll_reg;
         3'd2:    reg_rd_val = vscroll_reg;
         3'd3:    reg_rd_val = 16'(en_reg);
         3'd4:    reg_rd_val = 16'(bg_reg);
         default: reg_rd_val = '0;
      endcase
   end

   // Source select and register snapshot only move on ren, so rdata holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid     <= 1'b0;
         rd_src_reg <= SRC_NONE;
         reg_rd_reg <= '0;
      end else begin
         rvalid <= ren;
         if (ren) begin
            rd_src_reg <= rd_src;
            reg_rd_reg <= reg_rd_val;
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (rd_src_reg)
         SRC_TS:  rdata = ts_cpu_reg;
         SRC_FB:  rdata = fb_cpu_reg;
         SRC_REG: rdata = reg_rd_reg;
         default: rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_tile_video_mem.sv
// Bench for tile_video_mem: directed vector table, hand-written shadow/CPU/reset sequences,
// and randomized pixel streams checked against an arithmetic reference model.
module tb_tile_video_mem;

   localparam int TS_BASE = 16'hC000;
   localparam int FBB     = 16'hE000;
   localparam int RB      = 16'hFFF8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ren = 1'b0;
   logic [15:0] raddr = '0;
   logic [15:0] rdata;
   logic        rvalid;
   logic        wen = 1'b0;
   logic [15:0] waddr = '0;
   logic [15:0] wdata = '0;
   logic        frame_start = 1'b0;
   logic        pix_req = 1'b0;
   logic [9:0]  pixel_x = '0;
   logic [9:0]  pixel_y = '0;
   logic [11:0] pixel;
   logic        pixel_valid;

   tile_video_mem dut (
      .clk(clk), .rst_n(rst_n), .ren(ren), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
      .wen(wen), .waddr(waddr), .wdata(wdata), .frame_start(frame_start),
      .pix_req(pix_req), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pixel(pixel), .pixel_valid(pixel_valid)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Reference model state
   int m_ts [8192];
   int m_fb [4096];
   int m_scale, m_h, m_v, m_en, m_bg;
   int sh_scale, sh_h, sh_v;

   typedef struct {
      int scale, hs, vs, ctrl, bg, x, y, expp;
   } vec_t;

   typedef struct {
      int v;
      int p;
   } exp_t;

   vec_t vecs[12];
   exp_t q[$];
   exp_t e;
   int   d;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic int model_pixel(input int x, input int y);
      int es, mx, my, tile, word, idx;
      es   = (sh_scale > 3) ? 3 : sh_scale;
      mx   = ((x / (1 << es)) + sh_h) % 1024;
      my   = ((y / (1 << es)) + sh_v) % 512;
      tile = (my / 8) * 128 + (mx / 8);
      word = m_fb[tile / 2];
      idx  = (tile % 2 == 1) ? (word / 256) % 128 : word % 128;
      if (m_en == 0)
         return m_bg;
      return m_ts[idx * 64 + (my % 8) * 8 + (mx % 8)] % 4096;
   endfunction

   task automatic cpu_write(input int a, input int dat);
      wen = 1'b1; waddr = 16'(a); wdata = 16'(dat);
      @(posedge clk); #1;
      wen = 1'b0;
   endtask

   task automatic cpu_read(input int a, output int dat);
      ren = 1'b1; raddr = 16'(a);
      @(posedge clk); #1;
      ren = 1'b0;
      check("rvalid", int'(rvalid), 1);
      dat = int'(rdata);
   endtask

   task automatic set_regs(input int s, input int h, input int v, input int c, input int bg);
      cpu_write(RB + 0, s);
      cpu_write(RB + 1, h);
      cpu_write(RB + 2, v);
      cpu_write(RB + 3, c);
      cpu_write(RB + 4, bg);
      m_scale = s % 4; m_h = h % 65536; m_v = v % 65536; m_en = c % 2; m_bg = bg % 4096;
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      sh_scale = m_scale; sh_h = m_h; sh_v = m_v;
   endtask

   task automatic fetch(input string name, input int x, input int y, input int exp);
      pix_req = 1'b1; pixel_x = 10'(x); pixel_y = 10'(y);
      @(posedge clk); #1;
      pix_req = 1'b0;
      check({name, " valid+1"}, int'(pixel_valid), 0);
      @(posedge clk); #1;
      check({name, " valid+2"}, int'(pixel_valid), 0);
      @(posedge clk); #1;
      check({name, " valid+3"}, int'(pixel_valid), 1);
      check({name, " pixel"}, int'(pixel), exp);
      @(posedge clk); #1;
      check({name, " valid+4"}, int'(pixel_valid), 0);
      $display("fetch %s: x=%0d y=%0d pixel=%03h", name, x, y, pixel);
   endtask

   initial begin
      vecs[0]  = '{0, 0,    0,     1, 0,        0,  0,  12'hF00};
      vecs[1]  = '{0, 8,    0,     1, 0,        0,  0,  12'hABC};
      vecs[2]  = '{0, 1023, 0,     1, 0,        1,  0,  12'hF00};
      vecs[3]  = '{0, 1024, 0,     1, 0,        8,  0,  12'hABC};
      vecs[4]  = '{3, 0,    0,     1, 0,        63, 0,  12'h777};
      vecs[5]  = '{7, 0,    0,     1, 0,        63, 0,  12'h777};
      vecs[6]  = '{2, 0,    0,     1, 0,        20, 0,  12'h456};
      vecs[7]  = '{0, 0,    1,     1, 0,        0,  0,  12'h555};
      vecs[8]  = '{0, 0,    511,   1, 0,        0,  1,  12'hF00};
      vecs[9]  = '{0, 0,    0,     1, 0,        9,  10, 12'hE0D};
      vecs[10] = '{0, 0,    0,     0, 16'hF123, 0,  0,  12'h123};
      vecs[11] = '{1, 0,    65535, 1, 0,        0,  2,  12'hF00};

      m_scale = 0; m_h = 0; m_v = 0; m_en = 0; m_bg = 0;
      sh_scale = 0; sh_h = 0; sh_v = 0;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset rdata", int'(rdata), 0);
      check("reset rvalid", int'(rvalid), 0);
      check("reset pixel", int'(pixel), 0);
      check("reset pixel_valid", int'(pixel_valid), 0);
      for (int i = 0; i < 5; i++) begin
         cpu_read(RB + i, d);
         check($sformatf("reset reg%0d", i), d, 0);
      end

      // Known content for the directed vectors
      cpu_write(TS_BASE + 64,  16'h0F00);
      cpu_write(TS_BASE + 0,   16'h0ABC);
      cpu_write(TS_BASE + 71,  16'h0777);
      cpu_write(TS_BASE + 69,  16'h0456);
      cpu_write(TS_BASE + 72,  16'h0555);
      cpu_write(TS_BASE + 209, 16'hFE0D);
      cpu_write(FBB + 0,       16'h0001);
      cpu_write(FBB + 64,      16'h8300);

      for (int i = 0; i < 12; i++) begin
         set_regs(vecs[i].scale, vecs[i].hs, vecs[i].vs, vecs[i].ctrl, vecs[i].bg);
         pulse_frame();
         fetch($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].expp);
      end

      // Shadow timing, including a write coinciding with frame_start
      set_regs(0, 0, 0, 1, 0);
      pulse_frame();
      fetch("shadow_base", 0, 0, 12'hF00);
      cpu_write(RB + 1, 8);
      fetch("shadow_pending", 0, 0, 12'hF00);
      cpu_read(RB + 1, d);
      check("hscroll live", d, 8);
      pulse_frame();
      fetch("shadow_loaded", 0, 0, 12'hABC);
      wen = 1'b1; waddr = 16'(RB + 1); wdata = 16'h0000; frame_start = 1'b1;
      @(posedge clk); #1;
      wen = 1'b0; frame_start = 1'b0;
      fetch("fs_same_cycle", 0, 0, 12'hABC);
      pulse_frame();
      fetch("fs_next", 0, 0, 12'hF00);

      // CPU port corner cases
      cpu_write(FBB + 5, 16'h1111);
      ren = 1'b1; raddr = 16'(FBB + 5); wen = 1'b1; waddr = 16'(FBB + 5); wdata = 16'h2222;
      @(posedge clk); #1;
      ren = 1'b0; wen = 1'b0;
      check("rw same cycle rvalid", int'(rvalid), 1);
      check("rw same cycle old data", int'(rdata), 16'h1111);
      @(posedge clk); #1;
      check("rvalid idle", int'(rvalid), 0);
      check("rdata hold", int'(rdata), 16'h1111);
      cpu_read(FBB + 5, d);
      check("fb new data", d, 16'h2222);
      cpu_write(16'h0100, 16'hBEEF);
      cpu_read(16'h0100, d);
      check("low addr read", d, 0);
      cpu_write(RB + 5, 16'hFFFF);
      cpu_read(RB + 5, d);
      check("reserved reg", d, 0);
      cpu_read(RB + 4, d);
      check("bg readback", d, 0);
      cpu_read(TS_BASE + 64, d);
      check("tile readback", d, 16'h0F00);
      $display("cpu port corner cases done");

      // Randomized fill and pixel streams
      for (int i = 0; i < 8192; i++) begin
         m_ts[i] = int'($urandom_range(0, 65535));
         cpu_write(TS_BASE + i, m_ts[i]);
      end
      for (int i = 0; i < 4096; i++) begin
         m_fb[i] = int'($urandom_range(0, 65535));
         cpu_write(FBB + i, m_fb[i]);
      end
      for (int r = 0; r < 4; r++) begin
         set_regs(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 65535)), (r == 3) ? 0 : 1,
                  int'($urandom_range(0, 4095)));
         pulse_frame();
         $display("round %0d: scale=%0d hscroll=%0d vscroll=%0d en=%0d", r, m_scale, m_h, m_v, m_en);
         q.delete();
         for (int i = 0; i < 150; i++) begin
            int rq, x, y;
            rq = int'($urandom_range(0, 1));
            x  = int'($urandom_range(0, 1023));
            y  = int'($urandom_range(0, 1023));
            pix_req = 1'(rq); pixel_x = 10'(x); pixel_y = 10'(y);
            q.push_back('{rq, model_pixel(x, y)});
            @(posedge clk); #1;
            if (q.size() == 3) begin
               e = q.pop_front();
               check("stream valid", int'(pixel_valid), e.v);
               if (e.v == 1)
                  check("stream pixel", int'(pixel), e.p);
            end
         end
         pix_req = 1'b0;
         repeat (3) @(posedge clk);
         #1;
      end

      // Reset in the middle of a request stream
      pix_req = 1'b1; pixel_x = '0; pixel_y = '0;
      repeat (4) @(posedge clk);
      #1;
      check("stream before reset", int'(pixel_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("reset pixel_valid async", int'(pixel_valid), 0);
      check("reset pixel async", int'(pixel), 0);
      pix_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      m_scale = 0; m_h = 0; m_v = 0; m_en = 0; m_bg = 0;
      sh_scale = 0; sh_h = 0; sh_v = 0;
      cpu_read(RB + 1, d);
      check("post reset hscroll", d, 0);
      cpu_read(RB + 3, d);
      check("post reset ctrl", d, 0);
      cpu_write(RB + 3, 1);
      m_en = 1;
      fetch("post_reset_shadow", 0, 0, model_pixel(0, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
